// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer behind FFT_IFFT: captures frames in any address order
// and replays each one in natural bin order over a valid/ready stream.
module fft_out_reorder #(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_WIDTH_P  = 18
) (
  input  logic                     iclk,
  input  logic                     rst_n,
  input  logic [TOTAL_STAGE_P-1:0] iaddr,
  input  logic [MULT_WIDTH_P-1:0]  iReal,
  input  logic [MULT_WIDTH_P-1:0]  iImag,
  input  logic                     ien,
  output logic [MULT_WIDTH_P-1:0]  oReal,
  output logic [MULT_WIDTH_P-1:0]  oImag,
  output logic [TOTAL_STAGE_P-1:0] oaddr,
  output logic                     ovalid,
  input  logic                     iready,
  output logic                     olast,
  output logic                     odrop
);

  localparam int N_PTS = 1 << TOTAL_STAGE_P;
  localparam int DW    = 2 * MULT_WIDTH_P;
  localparam logic [TOTAL_STAGE_P-1:0] LAST_ADDR = '1;
  localparam logic [TOTAL_STAGE_P-1:0] ADDR_ONE  = TOTAL_STAGE_P'(1);

  localparam logic [1:0] RIDLE  = 2'd0;
  localparam logic [1:0] RFETCH = 2'd1;
  localparam logic [1:0] RSEND  = 2'd2;

  // Both banks share one array; the bank number is the top address bit.
  logic [DW-1:0] r_mem [0:2*N_PTS-1];

  logic [TOTAL_STAGE_P-1:0] r_wcnt;
  logic                     r_wbank;
  logic                     r_discard;
  logic                     r_drop;
  logic [1:0]               r_full;

  logic [1:0]               r_state;
  logic                     r_rbank;
  logic [TOTAL_STAGE_P-1:0] r_issueAddr;
  logic                     r_s1Valid;
  logic [TOTAL_STAGE_P-1:0] r_s1Addr;
  logic [DW-1:0]            r_s1Data;

  logic                     r_oValid;
  logic [TOTAL_STAGE_P-1:0] r_oAddr;
  logic [DW-1:0]            r_oData;
  logic                     r_oLast;

  logic w_wFirst;
  logic w_discard;
  logic w_wrEn;
  logic w_wLast;
  logic w_setFull;
  logic w_outAccept;
  logic w_xfer;
  logic w_s1Free;
  logic w_issue;
  logic w_clrFull;

  // The discard decision is taken live on the first sample, then held for the frame.
  assign w_wFirst  = (r_wcnt == '0);
  assign w_discard = w_wFirst ? r_full[r_wbank] : r_discard;
  assign w_wrEn    = ien && !w_discard;
  assign w_wLast   = ien && (r_wcnt == LAST_ADDR);
  assign w_setFull = w_wLast && !w_discard;

  assign w_outAccept = !r_oValid || iready;
  assign w_xfer      = r_oValid && iready;
  assign w_s1Free    = !r_s1Valid || w_outAccept;
  assign w_issue     = w_s1Free &&
                       ((r_state == RFETCH) || ((r_state == RIDLE) && r_full[r_rbank]));
  assign w_clrFull   = (r_state == RSEND) && w_xfer && r_oLast;

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt    <= '0;
      r_wbank   <= 1'b0;
      r_discard <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= w_wLast && w_discard;
      if (ien) begin
        r_wcnt <= r_wcnt + ADDR_ONE;
        if (w_wFirst) begin
          r_discard <= r_full[r_wbank];
        end
        if (w_setFull) begin
          r_wbank <= ~r_wbank;
        end
      end
    end
  end

  // Writer and reader never target the same bank in one cycle, so both updates apply.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      if (w_setFull) begin
        r_full[r_wbank] <= 1'b1;
      end
      if (w_clrFull) begin
        r_full[r_rbank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (w_wrEn) begin
      r_mem[{r_wbank, iaddr}] <= {iReal, iImag};
    end
    if (w_issue) begin
      r_s1Data <= r_mem[{r_rbank, r_issueAddr}];
    end
  end

  // Reads are issued whenever the fetch stage can drain, giving one sample per cycle.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RIDLE;
      r_rbank     <= 1'b0;
      r_issueAddr <= '0;
      r_s1Valid   <= 1'b0;
      r_s1Addr    <= '0;
    end else begin
      if (w_issue) begin
        r_issueAddr <= r_issueAddr + ADDR_ONE;
        r_s1Addr    <= r_issueAddr;
        r_s1Valid   <= 1'b1;
      end else if (w_s1Free) begin
        r_s1Valid <= 1'b0;
      end

      case (r_state)
        RIDLE: begin
          if (w_issue) begin
            r_state <= (r_issueAddr == LAST_ADDR) ? RSEND : RFETCH;
          end
        end
        RFETCH: begin
          if (w_issue && (r_issueAddr == LAST_ADDR)) begin
            r_state <= RSEND;
          end
        end
        RSEND: begin
          if (w_clrFull) begin
            r_state <= RIDLE;
            r_rbank <= ~r_rbank;
          end
        end
        default: begin
          r_state <= RIDLE;
        end
      endcase
    end
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      r_oValid <= 1'b0;
      r_oAddr  <= '0;
      r_oData  <= '0;
      r_oLast  <= 1'b0;
    end else if (w_outAccept) begin
      r_oValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_oAddr <= r_s1Addr;
        r_oData <= r_s1Data;
        r_oLast <= (r_s1Addr == LAST_ADDR);
      end else begin
        r_oLast <= 1'b0;
      end
    end
  end

  assign oReal  = r_oData[DW-1:MULT_WIDTH_P];
  assign oImag  = r_oData[MULT_WIDTH_P-1:0];
  assign oaddr  = r_oAddr;
  assign ovalid = r_oValid;
  assign olast  = r_oLast;
  assign odrop  = r_drop;

endmodule
